// File: rtl/spi_slave_regfile.sv
// SPI responder with a small register file: a command byte (R/W + address) then a data byte.
// All SPI pins are oversampled in the clk domain; every action happens one clk after edge detection.
module spi_slave_regfile #(
    parameter int unsigned SPI_MODE = 1,
    parameter int unsigned SPI_TRF_BIT = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [SPI_TRF_BIT-1:0] STATUS_BYTE = 8'hA5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        sclk_i,
    input  logic                        cs_n_i,
    input  logic                        mosi_i,
    output logic                        miso_o,
    output logic                        miso_oe_o,
    output logic                        wr_valid_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
    output logic [SPI_TRF_BIT-1:0]      wr_data_o,
    output logic                        rd_valid_o,
    output logic                        addr_err_o,
    output logic                        frame_err_o,
    input  logic [$clog2(NUM_REGS)-1:0] loc_addr_i,
    output logic [SPI_TRF_BIT-1:0]      loc_rdata_o
);
    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned CW = $clog2(SPI_TRF_BIT);
    localparam bit Cpol = SPI_MODE[1];
    localparam bit Cpha = SPI_MODE[0];
    localparam bit SampleRise = (Cpol == Cpha);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StHold} state_e;
    state_e state_q, state_d;

    logic sclk_q1, sclk_q2, sclk_prev_q;
    logic cs_q1, cs_q2, cs_prev_q;
    logic mosi_q1, mosi_q2;
    logic [1:0] settle_q;

    logic [CW-1:0] bit_cnt_q;
    logic [SPI_TRF_BIT-1:0] rx_shift_q, tx_shift_q, cmd_q;
    logic miso_q, skip_q;
    logic [SPI_TRF_BIT-1:0] regs_q [NUM_REGS];

    logic wr_valid_d, rd_valid_d, addr_err_d, frame_err_d;
    logic wr_valid_q, rd_valid_q, addr_err_q, frame_err_q;
    logic [AW-1:0] wr_addr_q;
    logic [SPI_TRF_BIT-1:0] wr_data_q;

    logic sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall, sync_ok, byte_done;
    logic in_frame, rx_in_range, cmd_in_range;
    logic [SPI_TRF_BIT-1:0] rx_byte, load_byte;
    logic [SPI_TRF_BIT-2:0] rx_addr;

    always_comb begin
        sync_ok      = (settle_q == 2'd3);
        sclk_rise    = sclk_q2 & ~sclk_prev_q;
        sclk_fall    = ~sclk_q2 & sclk_prev_q;
        sample_edge  = SampleRise ? sclk_rise : sclk_fall;
        shift_edge   = SampleRise ? sclk_fall : sclk_rise;
        // Ignore the artificial cs_n fall seen while the chain refills after reset.
        cs_fall      = sync_ok & cs_prev_q & ~cs_q2;
        byte_done    = sample_edge && (bit_cnt_q == CW'(SPI_TRF_BIT - 1));
        rx_byte      = {rx_shift_q[SPI_TRF_BIT-2:0], mosi_q2};
        rx_addr      = rx_byte[SPI_TRF_BIT-2:0];
        rx_in_range  = (rx_addr >> AW) == '0;
        cmd_in_range = (cmd_q[SPI_TRF_BIT-2:0] >> AW) == '0;
        load_byte    = rx_byte[SPI_TRF_BIT-1] ? '0 :
                       (rx_in_range ? regs_q[rx_addr[AW-1:0]] : '1);
        in_frame     = (state_q == StCmd) || (state_q == StData);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StCmd;
            StCmd:   if (cs_q2) state_d = StIdle; else if (byte_done) state_d = StData;
            StData:  if (cs_q2) state_d = StIdle; else if (byte_done) state_d = StHold;
            StHold:  if (cs_q2) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_valid_d  = 1'b0;
        rd_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        frame_err_d = 1'b0;
        if (in_frame && cs_q2) begin
            frame_err_d = 1'b1;
        end else if (state_q == StData && byte_done) begin
            if (cmd_q[SPI_TRF_BIT-1]) begin
                wr_valid_d = cmd_in_range;
                addr_err_d = !cmd_in_range;
            end else begin
                rd_valid_d = 1'b1;
                addr_err_d = !cmd_in_range;
            end
        end
        miso_o = in_frame && !cs_q2 && (Cpha ? miso_q : tx_shift_q[SPI_TRF_BIT-1]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_q1     <= Cpol;
            sclk_q2     <= Cpol;
            sclk_prev_q <= Cpol;
            cs_q1       <= 1'b1;
            cs_q2       <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_q1     <= 1'b0;
            mosi_q2     <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            sclk_q1     <= sclk_i;
            sclk_q2     <= sclk_q1;
            sclk_prev_q <= sclk_q2;
            cs_q1       <= cs_n_i;
            cs_q2       <= cs_q1;
            cs_prev_q   <= cs_q2;
            mosi_q1     <= mosi_i;
            mosi_q2     <= mosi_q1;
            if (!sync_ok) settle_q <= settle_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            cmd_q       <= '0;
            miso_q      <= 1'b0;
            skip_q      <= 1'b0;
            regs_q      <= '{default: '0};
            wr_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_valid_q  <= wr_valid_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
            frame_err_q <= frame_err_d;
            if (wr_valid_d) begin
                regs_q[cmd_q[AW-1:0]] <= rx_byte;
                wr_addr_q <= cmd_q[AW-1:0];
                wr_data_q <= rx_byte;
            end
            if (state_q == StIdle) begin
                if (cs_fall) begin
                    bit_cnt_q  <= '0;
                    tx_shift_q <= STATUS_BYTE;
                    miso_q     <= 1'b0;
                    skip_q     <= 1'b0;
                end
            end else if (in_frame) begin
                if (sample_edge) begin
                    rx_shift_q <= rx_byte;
                    bit_cnt_q  <= byte_done ? '0 : bit_cnt_q + 1'b1;
                    if (byte_done && state_q == StCmd) begin
                        cmd_q      <= rx_byte;
                        tx_shift_q <= load_byte;
                        // CPHA=0 already presents the loaded MSB, so the next shift is swallowed.
                        skip_q     <= !Cpha;
                    end
                end else if (shift_edge) begin
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else begin
                        miso_q     <= tx_shift_q[SPI_TRF_BIT-1];
                        tx_shift_q <= tx_shift_q << 1;
                    end
                end
            end
        end
    end

    assign miso_oe_o   = ~cs_q2;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign addr_err_o  = addr_err_q;
    assign frame_err_o = frame_err_q;
    assign loc_rdata_o = regs_q[loc_addr_i];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench: one DUT per SPI mode, driven by a bit-banged master with hand-computed results.
module tb_spi_slave_regfile;
    localparam int Half = 80;

    logic clk = 1'b0;
    logic rst_n;
    logic mosi;
    logic [3:0] sclk, cs_n, miso, miso_oe, wr_valid, rd_valid, addr_err, frame_err;
    logic [3:0][3:0] wr_addr, loc_addr;
    logic [3:0][7:0] wr_data, loc_rdata;

    int wr_cnt[4] = '{default: 0};
    int rd_cnt[4] = '{default: 0};
    int ae_cnt[4] = '{default: 0};
    int fe_cnt[4] = '{default: 0};
    logic [3:0] last_wa[4];
    logic [7:0] last_wd[4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_regfile #(
            .SPI_MODE(g),
            .SPI_TRF_BIT(8),
            .NUM_REGS(16),
            .STATUS_BYTE(8'hA5)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .sclk_i     (sclk[g]),
            .cs_n_i     (cs_n[g]),
            .mosi_i     (mosi),
            .miso_o     (miso[g]),
            .miso_oe_o  (miso_oe[g]),
            .wr_valid_o (wr_valid[g]),
            .wr_addr_o  (wr_addr[g]),
            .wr_data_o  (wr_data[g]),
            .rd_valid_o (rd_valid[g]),
            .addr_err_o (addr_err[g]),
            .frame_err_o(frame_err[g]),
            .loc_addr_i (loc_addr[g]),
            .loc_rdata_o(loc_rdata[g])
        );
    end

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (wr_valid[m]) begin
                wr_cnt[m]++;
                last_wa[m] = wr_addr[m];
                last_wd[m] = wr_data[m];
            end
            if (rd_valid[m]) rd_cnt[m]++;
            if (addr_err[m]) ae_cnt[m]++;
            if (frame_err[m]) fe_cnt[m]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic loc_chk(input int m, input logic [3:0] a, input logic [7:0] exp, input string tag);
        loc_addr[m] = a;
        @(negedge clk);
        check(tag, 32'(loc_rdata[m]), 32'(exp));
    endtask

    // Master: nbits clocks, MSB of tx first; rst_at >= 0 pulses reset before that bit.
    task automatic xfer(input int m, input int nbits, input logic [23:0] tx, input int rst_at,
                        output logic [23:0] rx);
        logic cpha;
        cpha = (m % 2) == 1;
        rx = '0;
        @(negedge clk);
        cs_n[m] = 1'b0;
        if (!cpha) mosi = tx[23];
        #Half;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(negedge clk) rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("rst_miso", 32'(miso[m]), 32'h0);
                check("rst_miso_oe", 32'(miso_oe[m]), 32'h0);
                rst_n = 1'b1;
            end
            if (cpha) begin
                mosi = tx[23-i];
                sclk[m] = ~sclk[m];
                #Half;
                rx[23-i] = miso[m];
                sclk[m] = ~sclk[m];
                #Half;
            end else begin
                sclk[m] = ~sclk[m];
                rx[23-i] = miso[m];
                #Half;
                sclk[m] = ~sclk[m];
                if (i < 23) mosi = tx[22-i];
                #Half;
            end
        end
        cs_n[m] = 1'b1;
        #(2 * Half);
    endtask

    // Runs one frame and checks the strobe counts it produced.
    task automatic frame(input int m, input int nbits, input logic [23:0] tx, input int rst_at,
                         input int ew, input int er, input int ea, input int ef,
                         input string tag, output logic [23:0] rx);
        int w0, r0, a0, f0;
        w0 = wr_cnt[m];
        r0 = rd_cnt[m];
        a0 = ae_cnt[m];
        f0 = fe_cnt[m];
        xfer(m, nbits, tx, rst_at, rx);
        check({tag, "_wr_cnt"}, 32'(wr_cnt[m] - w0), 32'(ew));
        check({tag, "_rd_cnt"}, 32'(rd_cnt[m] - r0), 32'(er));
        check({tag, "_aerr_cnt"}, 32'(ae_cnt[m] - a0), 32'(ea));
        check({tag, "_ferr_cnt"}, 32'(fe_cnt[m] - f0), 32'(ef));
    endtask

    task automatic write_read(input int m);
        logic [23:0] rx;
        string p;
        p = $sformatf("m%0d", m);
        frame(m, 16, 24'h835C00, -1, 1, 0, 0, 0, {p, "_wr"}, rx);
        check({p, "_wr_status"}, 32'(rx[23:16]), 32'hA5);
        check({p, "_wr_addr"}, 32'(last_wa[m]), 32'h3);
        check({p, "_wr_data"}, 32'(last_wd[m]), 32'h5C);
        loc_chk(m, 4'd3, 8'h5C, {p, "_loc3"});
        frame(m, 16, 24'h030000, -1, 0, 1, 0, 0, {p, "_rd"}, rx);
        check({p, "_rd_status"}, 32'(rx[23:16]), 32'hA5);
        check({p, "_rd_data"}, 32'(rx[15:8]), 32'h5C);
        loc_chk(m, 4'd3, 8'h5C, {p, "_loc3_after_rd"});
    endtask

    initial begin
        logic [23:0] rx;
        rst_n = 1'b0;
        mosi = 1'b0;
        cs_n = 4'hF;
        sclk = 4'b1100;
        loc_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_miso", 32'(miso[1]), 32'h0);
        check("reset_miso_oe", 32'(miso_oe[1]), 32'h0);
        check("reset_strobes", 32'({wr_valid[1], rd_valid[1], addr_err[1], frame_err[1]}), 32'h0);
        check("reset_loc0", 32'(loc_rdata[1]), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        write_read(1);

        frame(1, 16, 24'h951100, -1, 0, 0, 1, 0, "oor_wr", rx);
        loc_chk(1, 4'd5, 8'h00, "oor_wr_loc5");
        loc_chk(1, 4'd3, 8'h5C, "oor_wr_loc3");
        frame(1, 16, 24'h150000, -1, 0, 1, 1, 0, "oor_rd", rx);
        check("oor_rd_data", 32'(rx[15:8]), 32'hFF);

        frame(1, 11, 24'h873C00, -1, 0, 0, 0, 1, "abort", rx);
        loc_chk(1, 4'd7, 8'h00, "abort_loc7");
        frame(1, 16, 24'h873C00, -1, 1, 0, 0, 0, "after_abort", rx);
        check("after_abort_addr", 32'(last_wa[1]), 32'h7);
        loc_chk(1, 4'd7, 8'h3C, "after_abort_loc7");

        write_read(0);
        write_read(2);
        write_read(3);

        frame(1, 24, 24'h0300FF, -1, 0, 1, 0, 0, "extra", rx);
        check("extra_status", 32'(rx[23:16]), 32'hA5);
        check("extra_data", 32'(rx[15:8]), 32'h5C);
        check("extra_tail", 32'(rx[7:0]), 32'h00);

        frame(1, 16, 24'h82AA00, 12, 0, 0, 0, 0, "rst_mid", rx);
        for (int a = 0; a < 16; a++) loc_chk(1, 4'(a), 8'h00, $sformatf("rst_mid_loc%0d", a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
